fnd_display_scheduler: RTL and testbench

Shares the single 4-digit FND display among up to four 14-bit value sources: UART RX byte count, TX byte count, FIFO level, and similar. It drives the 14-bit `i_counter` input of the FND controller. Sources rotate automatically or are stepped manually by button, and a source that reports a new value temporarily overrides the display for a hold time. Values above 9999 are clamped so the 4-digit display never wraps.

---
 rtl/fnd_sched_pkg.sv | 31 +++
 rtl/fnd_tick_gen.sv | 29 ++
 rtl/fnd_display_scheduler.sv | 153 +++++++++++++++
 tb/tb_fnd_display_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fnd_sched_pkg.sv
// Shared types, widths and helpers for the FND display scheduler.
package fnd_sched_pkg;

    localparam int DISP_W = 14;
    localparam int SEL_W  = 2;
    localparam logic [DISP_W-1:0] DISP_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_AUTO     = 2'd0,
        ST_MANUAL   = 2'd1,
        ST_OVERRIDE = 2'd2
    } sched_state_t;

    function automatic logic [DISP_W-1:0] clamp_disp(input logic [DISP_W-1:0] v);
        return (v > DISP_MAX) ? DISP_MAX : v;
    endfunction

    // Priority encoder: lowest requesting source wins the display.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [3:0] v);
        logic [SEL_W-1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Prescaler producing a 1-cycle tick every TICK_CYC clocks; i_clr restarts the period.
module fnd_tick_gen #(
    parameter int TICK_CYC = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

    logic [PW-1:0] presc_r;

    // Prescaler counter, wraps at the last cycle of each tick period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else if (i_clr || (presc_r == PRESC_LAST)) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign o_tick = (presc_r == PRESC_LAST);

endmodule

// File: rtl/fnd_display_scheduler.sv
// Time-shares a 4-digit FND display among NUM_SRC value sources with
// auto-rotation, manual stepping and update-triggered override.
module fnd_display_scheduler
    import fnd_sched_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int TICK_CYC     = 100_000,
    parameter int ROTATE_TICKS = 3000,
    parameter int HOLD_TICKS   = 2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DISP_W-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]        i_src_upd,
    input  logic                      i_mode_btn,
    input  logic                      i_next_btn,
    output logic [DISP_W-1:0]         o_counter,
    output logic [SEL_W-1:0]          o_src_sel,
    output logic                      o_mode,
    output logic                      o_ovr
);

    localparam int MAX_TICKS = (ROTATE_TICKS > HOLD_TICKS) ? ROTATE_TICKS : HOLD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROTATE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SRC - 1);

    sched_state_t     state_r, state_n_s;
    logic [SEL_W-1:0] sel_r, sel_n_s, saved_sel_r, saved_sel_n_s, sel_inc_s;
    logic             ret_manual_r, ret_manual_n_s;
    logic             mode_r, ovr_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic             tick_s, clr_s, expire_s;
    logic [3:0]       upd_s;
    logic [DISP_W-1:0] sel_data_s, counter_r;

    fnd_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (clr_s),
        .o_tick (tick_s)
    );

    assign upd_s     = 4'(i_src_upd);
    assign sel_inc_s = (sel_r == SEL_LAST) ? {SEL_W{1'b0}} : sel_r + 2'd1;

    // Dwell/hold expiry; MANUAL has no timer.
    always_comb begin
        case (state_r)
            ST_AUTO:     expire_s = tick_s && (tick_cnt_r == ROT_LAST);
            ST_OVERRIDE: expire_s = tick_s && (tick_cnt_r == HOLD_LAST);
            default:     expire_s = 1'b0;
        endcase
    end

    // Next-state logic; the if-chain order sets event priority.
    always_comb begin
        state_n_s      = state_r;
        sel_n_s        = sel_r;
        saved_sel_n_s  = saved_sel_r;
        ret_manual_n_s = ret_manual_r;
        clr_s          = 1'b0;
        if (|upd_s) begin
            if (state_r != ST_OVERRIDE) begin
                saved_sel_n_s  = sel_r;
                ret_manual_n_s = (state_r == ST_MANUAL);
            end else begin
                saved_sel_n_s  = saved_sel_r;
            end
            state_n_s = ST_OVERRIDE;
            sel_n_s   = lowest_idx(upd_s);
            clr_s     = 1'b1;
        end else if (expire_s) begin
            clr_s = 1'b1;
            if (state_r == ST_OVERRIDE) begin
                state_n_s = ret_manual_r ? ST_MANUAL : ST_AUTO;
                sel_n_s   = saved_sel_r;
            end else begin
                sel_n_s   = sel_inc_s;
            end
        end else if (i_mode_btn) begin
            case (state_r)
                ST_AUTO: begin
                    state_n_s = ST_MANUAL;
                    clr_s     = 1'b1;
                end
                ST_MANUAL: begin
                    state_n_s = ST_AUTO;
                    clr_s     = 1'b1;
                end
                ST_OVERRIDE: ret_manual_n_s = ~ret_manual_r;
                default: begin
                    state_n_s = ST_AUTO;
                    clr_s     = 1'b1;
                end
            endcase
        end else if (i_next_btn && (state_r == ST_MANUAL)) begin
            sel_n_s = sel_inc_s;
        end else begin
            sel_n_s = sel_r;
        end
    end

    // Scheduler state, selection and mode/override output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_AUTO;
            sel_r        <= {SEL_W{1'b0}};
            saved_sel_r  <= {SEL_W{1'b0}};
            ret_manual_r <= 1'b0;
            mode_r       <= 1'b0;
            ovr_r        <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            sel_r        <= sel_n_s;
            saved_sel_r  <= saved_sel_n_s;
            ret_manual_r <= ret_manual_n_s;
            mode_r       <= (state_n_s == ST_OVERRIDE) ? ret_manual_n_s : (state_n_s == ST_MANUAL);
            ovr_r        <= (state_n_s == ST_OVERRIDE);
        end
    end

    // Tick counter for rotate dwell and override hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_s) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s && (state_r != ST_MANUAL)) begin
            tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    assign sel_data_s = i_src_data[DISP_W*int'(sel_r) +: DISP_W];

    // Clamped display value from the live data of the selected source.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r <= {DISP_W{1'b0}};
        end else begin
            counter_r <= clamp_disp(sel_data_s);
        end
    end

    assign o_counter = counter_r;
    assign o_src_sel = sel_r;
    assign o_mode    = mode_r;
    assign o_ovr     = ovr_r;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed, table-driven bench for fnd_display_scheduler with short tick timing.
module tb_fnd_display_scheduler;

    localparam int NUM_SRC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [41:0] i_src_data;
    logic [2:0]  i_src_upd;
    logic        i_mode_btn;
    logic        i_next_btn;
    logic [13:0] o_counter;
    logic [1:0]  o_src_sel;
    logic        o_mode;
    logic        o_ovr;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int          ncyc;
        logic [2:0]  upd;
        logic        mode;
        logic        nxt;
        logic [1:0]  sel;
        logic        md;
        logic        ovr;
        logic [13:0] cnt;
    } vec_t;

    vec_t vecs[$];

    fnd_display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .TICK_CYC     (10),
        .ROTATE_TICKS (4),
        .HOLD_TICKS   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_src_data (i_src_data),
        .i_src_upd  (i_src_upd),
        .i_mode_btn (i_mode_btn),
        .i_next_btn (i_next_btn),
        .o_counter  (o_counter),
        .o_src_sel  (o_src_sel),
        .o_mode     (o_mode),
        .o_ovr      (o_ovr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [2:0] u, input logic m, input logic x,
                       input logic [1:0] s, input logic md, input logic ov, input int c);
        vec_t v;
        v.ncyc = n; v.upd = u; v.mode = m; v.nxt = x;
        v.sel = s; v.md = md; v.ovr = ov; v.cnt = 14'(c);
        vecs.push_back(v);
    endtask

    // Pulses are driven for the first clock only, outputs checked after ncyc clocks.
    task automatic run_vec(input string tag, input vec_t v);
        i_src_upd  = v.upd;
        i_mode_btn = v.mode;
        i_next_btn = v.nxt;
        for (int c = 0; c < v.ncyc; c++) begin
            step();
            i_src_upd  = 3'b000;
            i_mode_btn = 1'b0;
            i_next_btn = 1'b0;
        end
        chk({tag, " sel"}, int'(o_src_sel), int'(v.sel));
        chk({tag, " mode"}, int'(o_mode), int'(v.md));
        chk({tag, " ovr"}, int'(o_ovr), int'(v.ovr));
        chk({tag, " counter"}, int'(o_counter), int'(v.cnt));
    endtask

    initial begin
        vec_t v;
        int   data_val[4];
        int   data_exp[4];

        // Elapsed clocks since reset release noted per row.
        add(2,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1234);  // t=2
        add(37, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1234);  // t=39
        add(1,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1234);  // t=40 rotate
        add(1,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 9999);  // clamp
        add(38, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 9999);  // t=79
        add(1,  3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 9999);  // t=80
        add(1,  3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 42);
        add(38, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 42);    // t=119
        add(1,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 42);    // t=120 wrap
        add(1,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1234);
        add(1,  3'b100, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1234);  // t=122 override
        add(1,  3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 42);
        add(48, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 42);    // t=171
        add(1,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 42);    // t=172 expiry
        add(1,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1234);
        add(38, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1234);  // t=211
        add(1,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1234);  // t=212 rotate
        add(1,  3'b110, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 9999);  // t=213 two upd
        add(29, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 9999);  // t=242
        add(1,  3'b100, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 9999);  // t=243 retrigger
        add(49, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 42);    // t=292
        add(1,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 42);    // t=293 restore
        add(39, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 9999);  // t=332
        add(1,  3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 9999);  // t=333 upd vs rotate
        add(50, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1234);  // t=383
        add(1,  3'b000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 9999);  // manual
        add(200, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 9999);
        add(1,  3'b000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 9999);
        add(1,  3'b000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 42);
        add(1,  3'b000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1234);
        add(1,  3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 9999);  // mode beats next
        add(1,  3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 9999);  // t=589 override
        add(1,  3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1234);  // ret_mode toggle
        add(48, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1234);  // t=638
        add(1,  3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1234);  // t=639 to MANUAL
        add(100, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 9999);
        add(1,  3'b100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 9999);
        add(1,  3'b000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 42);    // next ignored

        rst        = 1'b1;
        i_src_upd  = 3'b000;
        i_mode_btn = 1'b0;
        i_next_btn = 1'b0;
        i_src_data = {14'd42, 14'd12000, 14'd1234};
        repeat (3) step();
        chk("reset sel", int'(o_src_sel), 0);
        chk("reset mode", int'(o_mode), 0);
        chk("reset ovr", int'(o_ovr), 0);
        chk("reset counter", int'(o_counter), 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset while holding an override.
        rst = 1'b1;
        step();
        chk("midhold rst sel", int'(o_src_sel), 0);
        chk("midhold rst mode", int'(o_mode), 0);
        chk("midhold rst ovr", int'(o_ovr), 0);
        chk("midhold rst counter", int'(o_counter), 0);
        rst = 1'b0;
        v = '{2, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 14'd1234};
        run_vec("post rst t2", v);
        v = '{37, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 14'd1234};
        run_vec("post rst t39", v);
        v = '{1, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 14'd1234};
        run_vec("post rst t40", v);

        // Live data on the selected source around the clamp boundary.
        data_val = '{9999, 10000, 9998, 0};
        data_exp = '{9999, 9999, 9998, 0};
        for (int k = 0; k < 4; k++) begin
            i_src_data[27:14] = 14'(data_val[k]);
            step();
            chk($sformatf("live data %0d", data_val[k]), int'(o_counter), data_exp[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
